// File: rtl/css_pkg.sv
// Shared definitions for the borrow-select subtractor pipeline.
// Holds default widths, the slice-count helper and the slice type.
package css_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int SLICE_W_DEF = 8;

   typedef logic [SLICE_W_DEF-1:0] slice_t;

   // Number of slices, which is also the pipeline depth.
   function automatic int nslice(input int data_w, input int slice_w);
      return data_w / slice_w;
   endfunction

endpackage

// File: rtl/borrow_select_slice.sv
// Combinational borrow-select slice.
// Both borrow-in candidates (a-b and a-b-1) are formed in parallel and the
// late-arriving borrow select picks one, keeping the select off the
// subtract path.
module borrow_select_slice
   import css_pkg::*;
#(
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               bsel,
   output logic [SLICE_W-1:0] d,
   output logic               bo
);

   // The extra top bit of each candidate is the slice borrow out.
   logic [SLICE_W:0] cand0;
   logic [SLICE_W:0] cand1;

   assign cand0 = {1'b0, a} - {1'b0, b};
   assign cand1 = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, 1'b1};

   assign d  = bsel ? cand1[SLICE_W-1:0] : cand0[SLICE_W-1:0];
   assign bo = bsel ? cand1[SLICE_W]     : cand0[SLICE_W];

endmodule

// File: rtl/borrow_select_subtractor32_pipe.sv
// Pipelined subtractor: out_diff = in_a - in_b - in_bin, one slice per stage.
// Stage k resolves slice k with the registered borrow of stage k-1; the
// already-resolved low slices ride forward with it, and only the operand
// slices still to be resolved are carried (they shrink by one slice per stage).
// A single advance signal moves the whole pipe, so a stall freezes every stage.
// Optional feature macro: CSS_FLAGS_EN adds registered zero/negative/overflow
// flags aligned with out_diff.
module borrow_select_subtractor32_pipe
   import css_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_bin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_diff,
   output logic              out_bout
`ifdef CSS_FLAGS_EN
   ,
   output logic              out_zero,
   output logic              out_neg,
   output logic              out_ovf
`endif
);

   localparam int NSLICE = nslice(DATA_W, SLICE_W);
   localparam int LAST   = NSLICE - 1;

   if ((DATA_W % SLICE_W) != 0 || NSLICE < 2) begin : g_bad_cfg
      $error("DATA_W must be a multiple of SLICE_W with at least two slices");
   end

   // The whole pipe advances unless a valid result is waiting on the consumer.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   genvar k;
   for (k = 0; k < NSLICE; k++) begin : g_stage
      localparam int LOW = (k + 1) * SLICE_W;
      localparam int REM = DATA_W - LOW;

      logic               vld_q;
      logic               bo_q;
      logic [LOW-1:0]     diff_q;

      logic               vld_d;
      logic               bo_d;
      logic [LOW-1:0]     diff_d;
      logic [SLICE_W-1:0] a_sl;
      logic [SLICE_W-1:0] b_sl;
      logic               bsel;
      logic [SLICE_W-1:0] dsl_d;

      if (k == 0) begin : g_head
         assign a_sl   = in_a[SLICE_W-1:0];
         assign b_sl   = in_b[SLICE_W-1:0];
         assign bsel   = in_bin;
         assign vld_d  = in_valid;
         assign diff_d = dsl_d;
      end else begin : g_body
         assign a_sl   = g_stage[k-1].g_fwd.a_q[SLICE_W-1:0];
         assign b_sl   = g_stage[k-1].g_fwd.b_q[SLICE_W-1:0];
         assign bsel   = g_stage[k-1].bo_q;
         assign vld_d  = g_stage[k-1].vld_q;
         assign diff_d = {dsl_d, g_stage[k-1].diff_q};
      end

      borrow_select_slice #(
         .SLICE_W (SLICE_W)
      ) u_slice (
         .a    (a_sl),
         .b    (b_sl),
         .bsel (bsel),
         .d    (dsl_d),
         .bo   (bo_d)
      );

      // Stage k: capture resolved low slices and this slice's borrow.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q  <= 1'b0;
            bo_q   <= 1'b0;
            diff_q <= '0;
         end else if (adv) begin
            vld_q <= vld_d;
            if (vld_d) begin
               bo_q   <= bo_d;
               diff_q <= diff_d;
            end
         end
      end

      if (k < LAST) begin : g_fwd
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;
         logic [REM-1:0] a_d;
         logic [REM-1:0] b_d;

         if (k == 0) begin : g_src_in
            assign a_d = in_a[DATA_W-1:SLICE_W];
            assign b_d = in_b[DATA_W-1:SLICE_W];
         end else begin : g_src_prev
            assign a_d = g_stage[k-1].g_fwd.a_q[REM+SLICE_W-1:SLICE_W];
            assign b_d = g_stage[k-1].g_fwd.b_q[REM+SLICE_W-1:SLICE_W];
         end

         // Stage k: carry the operand slices not yet resolved.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && vld_d) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end

   assign out_valid = g_stage[LAST].vld_q;
   assign out_diff  = g_stage[LAST].diff_q;
   assign out_bout  = g_stage[LAST].bo_q;

`ifdef CSS_FLAGS_EN
   // Operand sign bits live in the top carried slice of the stage below the last.
   logic a_msb;
   logic b_msb;
   logic zero_d;
   logic neg_d;
   logic ovf_d;
   logic zero_q;
   logic neg_q;
   logic ovf_q;

   assign a_msb  = g_stage[LAST-1].g_fwd.a_q[SLICE_W-1];
   assign b_msb  = g_stage[LAST-1].g_fwd.b_q[SLICE_W-1];
   assign zero_d = (g_stage[LAST].diff_d == '0);
   assign neg_d  = g_stage[LAST].diff_d[DATA_W-1];
   assign ovf_d  = (a_msb ^ b_msb) & (neg_d ^ a_msb);

   // Final stage: flags registered together with out_diff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (adv && g_stage[LAST].vld_d) begin
         zero_q <= zero_d;
         neg_q  <= neg_d;
         ovf_q  <= ovf_d;
      end
   end

   assign out_zero = zero_q;
   assign out_neg  = neg_q;
   assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_select_subtractor32_pipe.sv
// Scoreboard bench for borrow_select_subtractor32_pipe.
// Driver pushes the arithmetic expectation on every accepted beat; a monitor
// pops and compares on every output handshake. Build with CSS_FLAGS_EN to
// cover the flag outputs.
module tb_borrow_select_subtractor32_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_diff;
   logic        out_bout;
`ifdef CSS_FLAGS_EN
   logic        out_zero;
   logic        out_neg;
   logic        out_ovf;
`endif

   borrow_select_subtractor32_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_bout  (out_bout)
`ifdef CSS_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_neg   (out_neg),
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] diff;
      logic        bout;
      logic        zero;
      logic        neg;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   rdy_rand = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected event did not happen within its bound", name);
   endtask

   // Reference: plain 33-bit arithmetic and signed range test.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
      exp_t        e;
      logic [32:0] full;
      longint      sr;
      full   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      e.diff = full[31:0];
      e.bout = full[32];
      e.zero = (full[31:0] == 32'd0);
      e.neg  = full[31];
      sr     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return e;
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin);
      int waited = 0;
      bit acc    = 1'b0;
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_bin   = bin;
      in_valid = 1'b1;
      while (!acc && waited < 500) begin
         #4;
         acc = in_ready;
         @(posedge clk);
         if (acc) exp_q.push_back(model(a, b, bin));
         else begin
            waited++;
            @(negedge clk);
         end
      end
      if (!acc) fail_now("accept_timeout");
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int i = 0;
      while ((exp_q.size() != 0 || out_valid) && i < 3000) begin
         @(negedge clk);
         i++;
      end
      if (exp_q.size() != 0 || out_valid) fail_now("drain_timeout");
   endtask

   // Random consumer backpressure, changed just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: handshake checking, stall stability and ready behaviour.
   initial begin
      bit          stall_prev = 1'b0;
      logic [31:0] held_diff  = '0;
      logic        held_bout  = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
            continue;
         end
         check("in_ready", in_ready, !out_valid || out_ready);
         if (stall_prev) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_hold", {out_bout, out_diff}, {held_bout, held_diff});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out: got diff 0x%0h with no beat outstanding", out_diff);
            end else begin
               e = exp_q.pop_front();
               check("result", {out_bout, out_diff}, {e.bout, e.diff});
`ifdef CSS_FLAGS_EN
               check("flags", {out_zero, out_neg, out_ovf}, {e.zero, e.neg, e.ovf});
`endif
            end
         end
         stall_prev = out_valid && !out_ready;
         held_diff  = out_diff;
         held_bout  = out_bout;
      end
   end

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_bin    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out", {out_bout, out_diff}, 33'd0);
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;

      // Basic op and exact latency.
      send(32'h0000_0005, 32'h0000_0003, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("latency_early", out_valid, 1'b0);
      end
      @(negedge clk);
      check("latency_due", out_valid, 1'b1);
      drain();

      // Cross-slice borrows and boundaries.
      send(32'h0000_0100, 32'h0000_0001, 1'b0);
      send(32'h0000_0000, 32'h0000_0000, 1'b1);
      send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
      send(32'h0000_0000, 32'h0000_0000, 1'b0);
      send(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      send(32'h0001_0000, 32'h0000_0001, 1'b1);
      drain();

      // Backpressure: six beats, consumer stalls five cycles after first result.
      fork
         begin
            for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
         end
         begin
            int t = 0;
            while (!out_valid && t < 50) begin
               @(posedge clk);
               #1;
               t++;
            end
            if (!out_valid) fail_now("bp_first_valid");
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_out", {out_bout, out_diff}, 33'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_out_after_rst", seen, 0);
      send(32'h0000_0010, 32'h0000_0020, 1'b0);
      drain();

`ifdef CSS_FLAGS_EN
      send(32'h8000_0000, 32'h0000_0001, 1'b0);
      send(32'h1234_5678, 32'h1234_5678, 1'b0);
      send(32'h8000_0000, 32'h0000_0000, 1'b1);
      drain();
`endif

      // Random back-to-back stream with random consumer readiness.
      rdy_rand = 1'b1;
      for (int i = 0; i < 10000; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
      drain();
      rdy_rand = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
